bb_bidir_bank: RTL
==================

// Module: bb_bidir_bank
// PURPOSE
//  Parametrised successor to the single-bit bidirectional buffer: a WIDTH-bit registered
//  bidirectional pad bank with a direction state machine, programmable bus-turnaround gap,
//  valid/ready transmit handshake and synchronised receive path. Sits between core logic
//  and a shared half-duplex pad bus; TSALL keeps its global tristate-override role.
// PARAMETERS
//  WIDTH      8  bus/pad width in bits (1..64)
//  TURN_CYC   1  hi-Z guard cycles on every direction change (0..15; 0 = no guard states)
//  IN_STAGES  2  receive sampling register stages (1..3)
// PORTS
//  CLK       in     1      single clock, all state on rising edge
//  RSTN      in     1      asynchronous active-low reset
//  TSALL     in     1      1 = pad drive permitted; 0 = all pads hi-Z, combinational
//  TX_VALID  in     1      core requests drive / offers TX_DATA
//  TX_READY  out    1      word accepted on TX_VALID & TX_READY at CLK edge
//  TX_DATA   in     WIDTH  word to drive
//  RX_DATA   out    WIDTH  synchronised pad sample
//  RX_VALID  out    1      RX_DATA holds a sample taken while bank was receiving
//  DIR_TX    out    1      1 while pad drivers enabled (registered OE)
//  B         inout  WIDTH  pads
// BEHAVIOUR
//  Reset (RSTN=0, async): state=RX, OE_q=0 (B hi-Z at once), DOUT_q=0, turn counter=0,
//   TX_READY=0, RX_DATA=0, RX_VALID=0, DIR_TX=0. Reset mid-transfer drops drive immediately.
//  States: RX (hi-Z, receiving), TA_TX (guard before drive), TX (driving), TA_RX (guard after).
//  RX: TX_VALID=1 -> TA_TX, cnt loaded TURN_CYC-1; if TURN_CYC=0 -> TX directly.
//  TA_TX: cnt decrements; cnt=0 -> TX. TX_VALID=0 here -> RX (nothing driven, no guard).
//  TX: TX_READY = TSALL. Accept loads DOUT_q<=TX_DATA; OE_q<=1 on first accept.
//   Accepted word on B the cycle after acceptance. TX_VALID=0 -> OE_q<=0, state TA_RX
//   (RX if TURN_CYC=0). Last word stays on B exactly one cycle.
//  TA_RX: cnt TURN_CYC-1 down to 0 -> RX; TX_VALID ignored until RX reached.
//  TX_READY is 0 in all states but TX. First TX_READY = 1+TURN_CYC cycles after TX_VALID
//   first sampled high in RX.
//  B = (OE_q & TSALL) ? DOUT_q : 'z, per bit, same enable for all bits.
//  TSALL=0: B hi-Z same cycle, TX_READY=0, state/cnt/DOUT_q/OE_q hold; drive resumes
//   with same DOUT_q when TSALL returns.
//  DIR_TX = OE_q (not gated by TSALL).
//  Receive: B shifted through IN_STAGES regs every cycle; RX_DATA = last stage. Valid bit
//   enters pipe as (state==RX & ~OE_q) and travels with data; RX_VALID = its last stage.
//   RX_VALID=0 for any sample taken in TA_TX/TX/TA_RX, so own drive and guard cycles never
//   look valid.
//  Counter width $clog2(TURN_CYC+1), min 1; no wrap (loads only on state entry).
//  Simultaneous: TX_VALID falling at the edge of the TA_TX->TX transition enters TX, then
//   leaves next cycle with no accept and no drive.
// TESTING
//  1 Reset: RSTN=0 while driving 8'hA5 -> B=z within delta, all outputs 0; RSTN=1 -> state RX.
//  2 TURN_CYC=2: TX_VALID=1 at c0 -> TX_READY=1 at c3; words 11,22,33 accepted c3..c5
//    -> B=11,22,33 on c4..c6, z at c7; TX_VALID must not re-enter TX before c9.
//  3 IN_STAGES=2, B driven 5A externally in RX -> RX_DATA=5A, RX_VALID=1 two cycles later;
//    during own TX burst RX_VALID=0 throughout, incl. guard cycles.
//  4 TSALL=0 mid-burst (word 77 on B) -> B=z same cycle, TX_READY=0, no accepts; TSALL=1
//    -> B=77 again, accepts resume with next word.
//  5 TURN_CYC=0: TX_VALID pulse for one word C3 -> TX_READY next cycle, B=C3 one cycle,
//    back to RX immediately; RX_VALID resumes IN_STAGES cycles later.
//  6 TX_VALID dropped in TA_TX -> return to RX, B never driven, DIR_TX stays 0.

Source files
------------

// File: rtl/bb_bidir_bank.sv
// WIDTH-bit registered bidirectional pad bank: direction FSM with bus-turnaround guard,
// valid/ready transmit handshake and a synchronised, validity-tagged receive pipeline.
module bb_bidir_bank #(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 1,
  parameter int IN_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             TSALL,
  input  logic             TX_VALID,
  output logic             TX_READY,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             DIR_TX,
  inout  wire  [WIDTH-1:0] B
);

  localparam int CNT_W = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TURN_LOAD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

  typedef enum logic [1:0] {
    ST_RX,
    ST_TA_TX,
    ST_TX,
    ST_TA_RX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             oe_q;
  logic [WIDTH-1:0] dout_q;

  logic [WIDTH-1:0] rx_pipe [IN_STAGES];
  logic [IN_STAGES-1:0] vld_pipe;
  logic             rx_in_valid;

  // The whole direction machine freezes while TSALL is low so drive resumes unchanged.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= ST_RX;
      cnt    <= '0;
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else if (TSALL) begin
      case (state)
        ST_RX: begin
          if (TX_VALID) begin
            if (TURN_CYC == 0) begin
              state <= ST_TX;
            end else begin
              state <= ST_TA_TX;
              cnt   <= TURN_LOAD;
            end
          end
        end
        ST_TA_TX: begin
          if (!TX_VALID) begin
            state <= ST_RX;
          end else if (cnt == '0) begin
            state <= ST_TX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_TX: begin
          if (TX_VALID) begin
            dout_q <= TX_DATA;
            oe_q   <= 1'b1;
          end else begin
            oe_q <= 1'b0;
            if (TURN_CYC == 0) begin
              state <= ST_RX;
            end else begin
              state <= ST_TA_RX;
              cnt   <= TURN_LOAD;
            end
          end
        end
        ST_TA_RX: begin
          if (cnt == '0) begin
            state <= ST_RX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

  assign TX_READY = TSALL && (state == ST_TX);
  assign DIR_TX   = oe_q;
  assign B        = (oe_q && TSALL) ? dout_q : {WIDTH{1'bz}};

  // Only samples taken while idle in RX with drivers off are tagged valid.
  assign rx_in_valid = (state == ST_RX) && !oe_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < IN_STAGES; i++) begin
        rx_pipe[i] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      rx_pipe[0]  <= B;
      vld_pipe[0] <= rx_in_valid;
      for (int i = 1; i < IN_STAGES; i++) begin
        rx_pipe[i]  <= rx_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign RX_DATA  = rx_pipe[IN_STAGES-1];
  assign RX_VALID = vld_pipe[IN_STAGES-1];

endmodule
